// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the decode-stage main control and the EX-stage ALU control decoder.
package cpu_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 11;
  localparam int unsigned REG_W   = 5;

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(31);
  localparam logic [REG_W-1:0] LINK_REG = REG_W'(30);

  typedef enum logic [1:0] {
    ALU_OP_PASSB = 2'b00,
    ALU_OP_ADD   = 2'b01,
    ALU_OP_SUB   = 2'b10,
    ALU_OP_OTHER = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_B    = 3'b001,
    BR_BL   = 3'b010,
    BR_BR   = 3'b011,
    BR_CBZ  = 3'b100,
    BR_BLT  = 3'b101
  } branch_e;

  // Opcode pattern: a bit participates in the match only where mask is 1.
  typedef struct packed {
    logic [OPC_W-1:0] value;
    logic [OPC_W-1:0] mask;
  } opc_pat_t;

  localparam opc_pat_t OPC_ADDI = '{value: 11'b10010001000, mask: 11'b11111111110};
  localparam opc_pat_t OPC_ADDS = '{value: 11'b10101011000, mask: 11'b11111111111};
  localparam opc_pat_t OPC_SUBS = '{value: 11'b11101011000, mask: 11'b11111111111};
  localparam opc_pat_t OPC_LDUR = '{value: 11'b11111000010, mask: 11'b11111111111};
  localparam opc_pat_t OPC_STUR = '{value: 11'b11111000000, mask: 11'b11111111111};
  localparam opc_pat_t OPC_CBZ  = '{value: 11'b10110100000, mask: 11'b11111111000};
  localparam opc_pat_t OPC_BLT  = '{value: 11'b01010100000, mask: 11'b11111111000};
  localparam opc_pat_t OPC_B    = '{value: 11'b00010100000, mask: 11'b11111100000};
  localparam opc_pat_t OPC_BL   = '{value: 11'b10010100000, mask: 11'b11111100000};
  localparam opc_pat_t OPC_BR   = '{value: 11'b11010110000, mask: 11'b11111111111};

  typedef struct packed {
    logic             valid;
    alu_op_e          alu_op;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             set_flags;
    branch_e          branch;
    logic [REG_W-1:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '{
    valid:      1'b0,
    alu_op:     ALU_OP_PASSB,
    alu_src:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    set_flags:  1'b0,
    branch:     BR_NONE,
    rd:         ZERO_REG
  };

  function automatic logic opc_match(input logic [OPC_W-1:0] opc, input opc_pat_t pat);
    return (opc & pat.mask) == pat.value;
  endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational opcode decode into a control bundle, plus which second source field the
// instruction reads (used by load-use detection).
module main_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  input  logic [REG_W-1:0] rd_field,
  output ctrl_bundle_t     ctrl_c,
  output logic             src_rm_c,
  output logic             src_rt_c,
  output logic             known_c
);

  always_comb begin
    ctrl_c       = BUBBLE;
    ctrl_c.valid = 1'b1;
    ctrl_c.rd    = rd_field;
    src_rm_c     = 1'b0;
    src_rt_c     = 1'b0;
    known_c      = 1'b1;
    if (opc_match(opc, OPC_ADDI)) begin
      ctrl_c.alu_op    = ALU_OP_ADD;
      ctrl_c.alu_src   = 1'b1;
      ctrl_c.reg_write = 1'b1;
    end else if (opc_match(opc, OPC_ADDS)) begin
      ctrl_c.alu_op    = ALU_OP_ADD;
      ctrl_c.set_flags = 1'b1;
      ctrl_c.reg_write = 1'b1;
      src_rm_c         = 1'b1;
    end else if (opc_match(opc, OPC_SUBS)) begin
      ctrl_c.alu_op    = ALU_OP_SUB;
      ctrl_c.set_flags = 1'b1;
      ctrl_c.reg_write = 1'b1;
      src_rm_c         = 1'b1;
    end else if (opc_match(opc, OPC_LDUR)) begin
      ctrl_c.alu_op     = ALU_OP_ADD;
      ctrl_c.alu_src    = 1'b1;
      ctrl_c.mem_read   = 1'b1;
      ctrl_c.mem_to_reg = 1'b1;
      ctrl_c.reg_write  = 1'b1;
    end else if (opc_match(opc, OPC_STUR)) begin
      ctrl_c.alu_op    = ALU_OP_ADD;
      ctrl_c.alu_src   = 1'b1;
      ctrl_c.mem_write = 1'b1;
      src_rt_c         = 1'b1;
    end else if (opc_match(opc, OPC_CBZ)) begin
      ctrl_c.branch = BR_CBZ;
      src_rt_c      = 1'b1;
    end else if (opc_match(opc, OPC_BLT)) begin
      ctrl_c.alu_op = ALU_OP_OTHER;
      ctrl_c.branch = BR_BLT;
    end else if (opc_match(opc, OPC_B)) begin
      ctrl_c.branch = BR_B;
    end else if (opc_match(opc, OPC_BL)) begin
      ctrl_c.branch    = BR_BL;
      ctrl_c.reg_write = 1'b1;
      ctrl_c.rd        = LINK_REG;
    end else if (opc_match(opc, OPC_BR)) begin
      ctrl_c.branch = BR_BR;
    end else begin
      known_c = 1'b0;
    end
  end

endmodule

// File: rtl/main_ctrl_pipe.sv
// Decode-stage main control: ID/EX control register, load-use hazard detection, stall and flush.
// Optional MAIN_CTRL_ILLEGAL_TRAP_EN: unmatched valid opcodes become bubbles and set sticky illegal_o.
module main_ctrl_pipe
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               if_id_valid,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic               load_use_stall,
  output logic               ex_valid,
  output logic [1:0]         ex_ALU_op,
  output logic               ex_ALU_src,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_set_flags,
  output logic [2:0]         ex_branch,
  output logic [REG_W-1:0]   ex_rd,
  output logic               illegal_o
);

  ctrl_bundle_t     dec;
  ctrl_bundle_t     idex_q;
  ctrl_bundle_t     idex_d;
  logic             src_rm;
  logic             src_rt;
  logic             known;
  logic [REG_W-1:0] rn;
  logic [REG_W-1:0] rm;
  logic [REG_W-1:0] rt;
  logic             unused_bits;

  assign rn          = instr[5 +: REG_W];
  assign rm          = instr[16 +: REG_W];
  assign rt          = instr[0 +: REG_W];
  assign unused_bits = ^instr[15:10];

  main_ctrl_decode u_decode (
    .opc      (instr[INSTR_W-1 -: OPC_W]),
    .rd_field (rt),
    .ctrl_c   (dec),
    .src_rm_c (src_rm),
    .src_rt_c (src_rt),
    .known_c  (known)
  );

  // A load in EX whose destination feeds this instruction must wait one cycle.
  assign load_use_stall = idex_q.valid && idex_q.mem_read && (idex_q.rd != ZERO_REG) && if_id_valid &&
                          ((idex_q.rd == rn) || (src_rm && (idex_q.rd == rm)) ||
                           (src_rt && (idex_q.rd == rt)));

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_d;

  always_comb begin
    idex_d    = idex_q;
    illegal_d = illegal_q;
    if (flush_in) begin
      idex_d = BUBBLE;
    end else if (stall_in) begin
      idex_d = idex_q;
    end else if (load_use_stall) begin
      idex_d = BUBBLE;
    end else if (if_id_valid && !known) begin
      idex_d    = BUBBLE;
      illegal_d = 1'b1;
    end else begin
      idex_d       = dec;
      idex_d.valid = if_id_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal_o = illegal_q;
`else
  logic unused_known;
  assign unused_known = known;

  always_comb begin
    idex_d = idex_q;
    if (flush_in) begin
      idex_d = BUBBLE;
    end else if (stall_in) begin
      idex_d = idex_q;
    end else if (load_use_stall) begin
      idex_d = BUBBLE;
    end else begin
      idex_d       = dec;
      idex_d.valid = if_id_valid;
    end
  end

  assign illegal_o = 1'b0;
`endif

  // ID/EX control register; reset leaves a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idex_q <= BUBBLE;
    else          idex_q <= idex_d;
  end

  assign ex_valid      = idex_q.valid;
  assign ex_ALU_op     = idex_q.alu_op;
  assign ex_ALU_src    = idex_q.alu_src;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_reg_write  = idex_q.reg_write;
  assign ex_mem_to_reg = idex_q.mem_to_reg;
  assign ex_set_flags  = idex_q.set_flags;
  assign ex_branch     = idex_q.branch;
  assign ex_rd         = idex_q.rd;

endmodule

// File: tb/tb_main_ctrl_pipe.sv
// Scoreboard bench for main_ctrl_pipe: a reference model pushes expected ID/EX contents and
// hazard flags; a monitor pops and compares every cycle.
module tb_main_ctrl_pipe;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        if_id_valid = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        load_use_stall;
  logic        ex_valid;
  logic [1:0]  ex_ALU_op;
  logic        ex_ALU_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_set_flags;
  logic [2:0]  ex_branch;
  logic [4:0]  ex_rd;
  logic        illegal_o;

  main_ctrl_pipe dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr          (instr),
    .if_id_valid    (if_id_valid),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .load_use_stall (load_use_stall),
    .ex_valid       (ex_valid),
    .ex_ALU_op      (ex_ALU_op),
    .ex_ALU_src     (ex_ALU_src),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_set_flags   (ex_set_flags),
    .ex_branch      (ex_branch),
    .ex_rd          (ex_rd),
    .illegal_o      (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       set_flags;
    logic [2:0] branch;
    logic [4:0] rd;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  bit   stall_q[$];
  exp_t model;
  int   errors = 0;
  int   checks = 0;
  int   hazards_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t bubble(input logic ill);
    exp_t e;
    e = '0;
    e.rd = 5'd31;
    e.ill = ill;
    return e;
  endfunction

  // Reference decode straight from the opcode table.
  function automatic void ref_decode(input logic [31:0] i, output exp_t e, output bit known,
                                     output bit uses_rm, output bit uses_rt);
    e = '0;
    e.valid = 1'b1;
    e.rd = i[4:0];
    known = 1'b1;
    uses_rm = 1'b0;
    uses_rt = 1'b0;
    casez (i[31:21])
      11'b1001000100?: begin e.alu_op = 2'd1; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      11'b10101011000: begin e.alu_op = 2'd1; e.set_flags = 1'b1; e.reg_write = 1'b1; uses_rm = 1'b1; end
      11'b11101011000: begin e.alu_op = 2'd2; e.set_flags = 1'b1; e.reg_write = 1'b1; uses_rm = 1'b1; end
      11'b11111000010: begin
        e.alu_op = 2'd1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      end
      11'b11111000000: begin e.alu_op = 2'd1; e.alu_src = 1'b1; e.mem_write = 1'b1; uses_rt = 1'b1; end
      11'b10110100???: begin e.branch = 3'd4; uses_rt = 1'b1; end
      11'b01010100???: begin e.alu_op = 2'd3; e.branch = 3'd5; end
      11'b000101?????: e.branch = 3'd1;
      11'b100101?????: begin e.branch = 3'd2; e.reg_write = 1'b1; e.rd = 5'd30; end
      11'b11010110000: e.branch = 3'd3;
      default:         known = 1'b0;
    endcase
  endfunction

  // Drive one cycle's inputs and predict the hazard flag and the next ID/EX contents.
  task automatic apply(input logic [31:0] i, input bit v, input bit s, input bit f, output bit hz);
    exp_t d;
    bit known, urm, urt;
    instr = i; if_id_valid = v; stall_in = s; flush_in = f;
    ref_decode(i, d, known, urm, urt);
    hz = model.valid && model.mem_read && model.rd != 5'd31 && v &&
         (model.rd == i[9:5] || (urm && model.rd == i[20:16]) || (urt && model.rd == i[4:0]));
    stall_q.push_back(hz);
    if (hz) hazards_seen++;
    if (f) model = bubble(model.ill);
    else if (s) model = model;
    else if (hz) model = bubble(model.ill);
    else if (TRAP && v && !known) model = bubble(1'b1);
    else begin
      d.valid = v;
      d.ill = model.ill;
      model = d;
    end
    exp_q.push_back(model);
  endtask

  task automatic step(input logic [31:0] i, input bit v, input bit s, input bit f, output bit hz);
    @(negedge clk); #1;
    apply(i, v, s, f, hz);
  endtask

  // Asynchronous reset in the middle of traffic, checked before any clock edge.
  task automatic mid_reset();
    bit hz;
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ex_ALU_op", 32'(ex_ALU_op), 32'd0);
    chk("reset ex_rd", 32'(ex_rd), 32'd31);
    chk("reset illegal_o", 32'(illegal_o), 32'd0);
    model = bubble(1'b0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    apply(instr, 1'b0, 1'b0, 1'b0, hz);
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 11);
    if (k != 11) begin
      i[4:0] = rreg(); i[9:5] = rreg(); i[20:16] = rreg();
    end
    case (k)
      0:  i[31:22] = 10'b1001000100;
      1:  i[31:21] = 11'b10101011000;
      2:  i[31:21] = 11'b11101011000;
      3:  i[31:21] = 11'b11111000010;
      4:  i[31:21] = 11'b11111000000;
      5:  i[31:24] = 8'b10110100;
      6:  i[31:24] = 8'b01010100;
      7:  i[31:26] = 6'b000101;
      8:  i[31:26] = 6'b100101;
      9:  i[31:21] = 11'b11010110000;
      10: i = 32'h0;
      default: ;
    endcase
    return i;
  endfunction

  // Monitor: registered outputs at the falling edge, the combinational hazard flag shortly after inputs settle.
  initial begin
    exp_t e;
    bit s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_ALU_op", 32'(ex_ALU_op), 32'(e.alu_op));
        chk("ex_ALU_src", 32'(ex_ALU_src), 32'(e.alu_src));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mem_read));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mem_write));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(e.reg_write));
        chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.mem_to_reg));
        chk("ex_set_flags", 32'(ex_set_flags), 32'(e.set_flags));
        chk("ex_branch", 32'(ex_branch), 32'(e.branch));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("illegal_o", 32'(illegal_o), 32'(e.ill));
      end
      #3;
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        chk("load_use_stall", 32'(load_use_stall), 32'(s));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit hz;
    bit prev_hz;
    logic [31:0] cur;
    model = bubble(1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("power-on ex_valid", 32'(ex_valid), 32'd0);
    chk("power-on ex_rd", 32'(ex_rd), 32'd31);
    reset_n = 1'b1;
    apply(32'h0, 1'b0, 1'b0, 1'b0, hz);

    step(32'hAB030041, 1, 0, 0, hz);            // ADDS X1,X2,X3
    step(32'hF8400045, 1, 0, 0, hz);            // LDUR X5,[X2]
    step(32'hAB0100A6, 1, 0, 0, hz);            // ADDS X6,X5,X1: hazard
    chk("load-use hazard raised", 32'(hz), 32'd1);
    step(32'hAB0100A6, 1, 0, 0, hz);            // re-presented, loads
    chk("load-use single bubble", 32'(hz), 32'd0);
    step(32'hF840005F, 1, 0, 0, hz);            // LDUR X31,[X2]
    step(32'hAB0103E6, 1, 0, 0, hz);            // ADDS X6,X31,X1: no hazard
    chk("X31 load no hazard", 32'(hz), 32'd0);
    step(32'hEB020027, 1, 0, 0, hz);            // SUBS X7,X1,X2
    repeat (3) step(32'h94000010, 1, 1, 0, hz); // held under stall
    step(32'h94000010, 1, 1, 1, hz);            // flush beats stall
    step(32'h94000010, 1, 0, 0, hz);            // BL
    step(32'hF8400045, 1, 0, 0, hz);            // LDUR X5 then invalid slot
    step(32'hAB0100A6, 0, 0, 0, hz);
    chk("no hazard when invalid", 32'(hz), 32'd0);
    step(32'h00000000, 1, 0, 0, hz);            // unmatched opcode
    step(32'hAB030041, 1, 0, 0, hz);            // sticky across valid instr
    mid_reset();

    prev_hz = 1'b0;
    cur = rand_instr();
    for (int n = 0; n < 600; n++) begin
      if (!prev_hz) cur = rand_instr();
      step(cur, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, hz);
      prev_hz = hz;
      if (n == 300) mid_reset();
    end

    repeat (3) @(negedge clk);
    #5;
    chk("scoreboard drained", 32'(exp_q.size() + stall_q.size()), 32'd0);
    if (hazards_seen < 2) begin
      errors++;
      $display("FAIL hazard coverage: got %0d expected at least 2", hazards_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
